// File: rtl/ddr_port_ctrl.sv
// ddr_port_ctrl: bridges the host di_* terminal bus onto one Spartan-6 MCB user port (bursts, commands, FIFO data, error status).
// Define DDR_PORT_CTRL_PREFETCH_EN to let reads issue bursts back-to-back; default keeps one read burst in flight.
module ddr_port_ctrl #(
  parameter logic [15:0] TERM_ADDR   = 16'h0010,
  parameter int          BURST_WORDS = 32
) (
  input  logic        ifclk,
  input  logic        resetb,
  input  logic [15:0] di_term_addr,
  input  logic [31:0] di_reg_addr,
  input  logic [31:0] di_len,
  input  logic        di_write_mode,
  input  logic        di_read_mode,
  input  logic        di_write,
  input  logic        di_read,
  input  logic [31:0] di_reg_datai,
  output logic [31:0] di_reg_datao,
  output logic        di_write_rdy,
  output logic        di_read_rdy,
  output logic [15:0] di_transfer_status,
  output logic        p_clk,
  output logic        p_cmd_en,
  output logic [2:0]  p_cmd_instr,
  output logic [5:0]  p_cmd_bl,
  output logic [29:0] p_cmd_byte_addr,
  input  logic        p_cmd_full,
  output logic        p_wr_en,
  output logic [3:0]  p_wr_mask,
  output logic [31:0] p_wr_data,
  input  logic        p_wr_full,
  input  logic        p_wr_underrun,
  input  logic        p_wr_error,
  output logic        p_rd_en,
  input  logic [31:0] p_rd_data,
  input  logic        p_rd_empty,
  input  logic        p_rd_overflow,
  input  logic        p_rd_error,
  input  logic [6:0]  p_rd_count
);
  typedef enum logic [2:0] {IDLE, WR_FILL, WR_CMD, RD_CMD, RD_DRAIN} state_t;
  localparam logic [6:0] BW = 7'(BURST_WORDS);

  state_t      state, state_nx;
  logic [29:0] addr, addr_nx;
  logic [29:0] remaining, remaining_nx;
  logic [6:0]  fill, fill_nx;
  logic [6:0]  outstanding, outstanding_nx;
  logic [6:0]  burst_n;
  logic [4:0]  status, status_nx;
  logic        wr_mode_q, rd_mode_q;
  logic        sel, wr_mode, rd_mode, burst_fits;
  logic        cmd_go;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic        unused_ok;

  assign sel     = (di_term_addr == TERM_ADDR);
  assign wr_mode = sel && di_write_mode;
  assign rd_mode = sel && di_read_mode;
  assign burst_n = (remaining > 30'(BURST_WORDS)) ? BW : remaining[6:0];

`ifdef DDR_PORT_CTRL_PREFETCH_EN
  assign burst_fits = ((8'(outstanding) + 8'(burst_n)) <= 8'd64);
`else
  assign burst_fits = (outstanding == 7'd0);
`endif

  assign p_clk              = ifclk;
  assign p_wr_mask          = 4'b0000;
  assign p_wr_data          = di_reg_datai;
  assign di_transfer_status = {11'd0, status};
  assign unused_ok          = ^{di_reg_addr[31:30], di_reg_addr[1:0], p_rd_count};

  always_comb begin
    state_nx       = state;
    addr_nx        = addr;
    fill_nx        = fill;
    remaining_nx   = remaining;
    outstanding_nx = outstanding;
    status_nx      = status | {1'b0, p_rd_error, p_rd_overflow, p_wr_error, p_wr_underrun};
    cmd_go         = 1'b0;
    cmd_instr      = 3'b000;
    cmd_bl         = 6'd0;
    di_write_rdy   = 1'b1;
    di_read_rdy    = 1'b1;
    di_reg_datao   = 32'd0;
    p_wr_en        = 1'b0;
    p_rd_en        = 1'b0;
    case (state)
      IDLE: begin
        // Leftovers of an aborted read are flushed before a new transfer may start.
        if (outstanding != 7'd0) begin
          p_rd_en        = !p_rd_empty;
          outstanding_nx = outstanding - 7'(p_rd_en);
        end else if (wr_mode && !wr_mode_q) begin
          state_nx  = WR_FILL;
          addr_nx   = {di_reg_addr[29:2], 2'b00};
          fill_nx   = 7'd0;
          status_nx = 5'd0;
        end else if (rd_mode && !rd_mode_q) begin
          state_nx     = RD_CMD;
          addr_nx      = {di_reg_addr[29:2], 2'b00};
          remaining_nx = di_len[31:2];
          status_nx    = {|di_len[1:0], 4'd0};
        end
      end
      WR_FILL: begin
        if (sel) begin
          di_write_rdy = !p_wr_full && (fill < BW);
          p_wr_en      = di_write && di_write_rdy;
        end
        fill_nx = fill + 7'(p_wr_en);
        if (fill_nx == BW) state_nx = WR_CMD;
        else if (!wr_mode) state_nx = (fill_nx != 7'd0) ? WR_CMD : IDLE;
      end
      WR_CMD: begin
        if (sel) di_write_rdy = 1'b0;
        if (!p_cmd_full) begin
          cmd_go    = 1'b1;
          cmd_instr = 3'b000;
          cmd_bl    = 6'(fill - 7'd1);
          addr_nx   = addr + 30'({fill, 2'b00});
          fill_nx   = 7'd0;
          state_nx  = wr_mode ? WR_FILL : IDLE;
        end
      end
      RD_CMD, RD_DRAIN: begin
        // Never pop beyond what was commanded, so stale FIFO words cannot underflow the count.
        if (sel) begin
          di_read_rdy  = !p_rd_empty && (outstanding != 7'd0);
          di_reg_datao = p_rd_data;
          p_rd_en      = di_read && di_read_rdy;
        end
        outstanding_nx = outstanding - 7'(p_rd_en);
        if (state == RD_DRAIN) begin
          if (outstanding == 7'd0 || !rd_mode) state_nx = IDLE;
        end else if (!rd_mode || remaining == 30'd0) begin
          state_nx = RD_DRAIN;
        end else if (!p_cmd_full && burst_fits) begin
          cmd_go         = 1'b1;
          cmd_instr      = 3'b001;
          cmd_bl         = 6'(burst_n - 7'd1);
          addr_nx        = addr + 30'({burst_n, 2'b00});
          remaining_nx   = remaining - 30'(burst_n);
          outstanding_nx = outstanding - 7'(p_rd_en) + burst_n;
          if (remaining_nx == 30'd0) state_nx = RD_DRAIN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      state           <= IDLE;
      addr            <= 30'd0;
      fill            <= 7'd0;
      remaining       <= 30'd0;
      outstanding     <= 7'd0;
      status          <= 5'd0;
      wr_mode_q       <= 1'b0;
      rd_mode_q       <= 1'b0;
      p_cmd_en        <= 1'b0;
      p_cmd_instr     <= 3'b000;
      p_cmd_bl        <= 6'd0;
      p_cmd_byte_addr <= 30'd0;
    end else begin
      state       <= state_nx;
      addr        <= addr_nx;
      fill        <= fill_nx;
      remaining   <= remaining_nx;
      outstanding <= outstanding_nx;
      status      <= status_nx;
      wr_mode_q   <= wr_mode;
      rd_mode_q   <= rd_mode;
      p_cmd_en    <= cmd_go;
      if (cmd_go) begin
        p_cmd_instr     <= cmd_instr;
        p_cmd_bl        <= cmd_bl;
        p_cmd_byte_addr <= addr;
      end
    end
  end
endmodule

// File: tb/tb_ddr_port_ctrl.sv
// Bench for ddr_port_ctrl: MCB port model, reference burst segmentation, table vectors, corner sequences and random transfers.
`timescale 1ns/1ps
module tb_ddr_port_ctrl;
  localparam logic [15:0] TERM = 16'h0010;
  localparam int BW = 32;

  logic        ifclk = 1'b0;
  logic        resetb = 1'b0;
  logic [15:0] di_term_addr = 16'h0;
  logic [31:0] di_reg_addr = 32'h0, di_len = 32'h0, di_reg_datai = 32'h0;
  logic        di_write_mode = 1'b0, di_read_mode = 1'b0, di_write = 1'b0, di_read = 1'b0;
  logic [31:0] di_reg_datao;
  logic        di_write_rdy, di_read_rdy;
  logic [15:0] di_transfer_status;
  logic        p_clk, p_cmd_en, p_wr_en, p_rd_en;
  logic [2:0]  p_cmd_instr;
  logic [5:0]  p_cmd_bl;
  logic [29:0] p_cmd_byte_addr;
  logic [3:0]  p_wr_mask;
  logic [31:0] p_wr_data;
  logic        p_cmd_full, p_wr_full, p_rd_error;
  logic [31:0] p_rd_data = 32'h0;
  logic        p_rd_empty = 1'b1;
  logic [6:0]  p_rd_count = 7'd0;
  logic        p_wr_underrun = 1'b0, p_wr_error = 1'b0, p_rd_overflow = 1'b0;

  bit force_wr_full = 0, rand_bp = 0, inject_rd_err = 0;
  bit rnd_cmd_full = 0, rnd_wr_full = 0;
  assign p_cmd_full = rnd_cmd_full;
  assign p_wr_full  = force_wr_full | rnd_wr_full;
  assign p_rd_error = inject_rd_err;

  always #5 ifclk = ~ifclk;

  ddr_port_ctrl #(.TERM_ADDR(TERM), .BURST_WORDS(BW)) dut (
    .ifclk(ifclk), .resetb(resetb), .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr),
    .di_len(di_len), .di_write_mode(di_write_mode), .di_read_mode(di_read_mode),
    .di_write(di_write), .di_read(di_read), .di_reg_datai(di_reg_datai), .di_reg_datao(di_reg_datao),
    .di_write_rdy(di_write_rdy), .di_read_rdy(di_read_rdy), .di_transfer_status(di_transfer_status),
    .p_clk(p_clk), .p_cmd_en(p_cmd_en), .p_cmd_instr(p_cmd_instr), .p_cmd_bl(p_cmd_bl),
    .p_cmd_byte_addr(p_cmd_byte_addr), .p_cmd_full(p_cmd_full), .p_wr_en(p_wr_en),
    .p_wr_mask(p_wr_mask), .p_wr_data(p_wr_data), .p_wr_full(p_wr_full),
    .p_wr_underrun(p_wr_underrun), .p_wr_error(p_wr_error), .p_rd_en(p_rd_en),
    .p_rd_data(p_rd_data), .p_rd_empty(p_rd_empty), .p_rd_overflow(p_rd_overflow),
    .p_rd_error(p_rd_error), .p_rd_count(p_rd_count)
  );

  typedef struct packed { logic [2:0] instr; logic [5:0] bl; logic [29:0] addr; } cmd_t;
  cmd_t        cmd_log[$];
  int          cmd_pops[$];
  cmd_t        exp_q[$];
  logic [31:0] wr_log[$], rd_fifo[$], pend[$];
  int          pops = 0, underflows = 0;
  int          errors = 0, checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory contents as seen by reads: a fixed scramble of the word address.
  function automatic logic [31:0] rdat(input logic [29:0] a);
    return (32'({a[29:2], 2'b00}) * 32'h9E3779B1) ^ 32'h0000_5A5A;
  endfunction

  // MCB port model: logs commands and writes, returns read bursts one word per cycle.
  always @(posedge ifclk) begin
    logic ce, we, re;
    cmd_t c;
    logic [31:0] wd;
    ce = p_cmd_en; c = {p_cmd_instr, p_cmd_bl, p_cmd_byte_addr};
    we = p_wr_en; wd = p_wr_data; re = p_rd_en;
    #1;
    if (!resetb) begin
      rd_fifo.delete(); pend.delete();
    end else begin
      if (we) wr_log.push_back(wd);
      if (re) begin
        if (rd_fifo.size() == 0) underflows++;
        else void'(rd_fifo.pop_front());
        pops++;
      end
      if (ce) begin
        cmd_log.push_back(c); cmd_pops.push_back(pops);
        if (c.instr == 3'b001)
          for (int i = 0; i <= int'(c.bl); i++) pend.push_back(rdat(c.addr + 30'(4 * i)));
      end
      if (pend.size() != 0 && rd_fifo.size() < 64) rd_fifo.push_back(pend.pop_front());
    end
    p_rd_empty   = (rd_fifo.size() == 0);
    p_rd_data    = p_rd_empty ? 32'h0 : rd_fifo[0];
    p_rd_count   = 7'(rd_fifo.size());
    rnd_cmd_full = rand_bp && ($urandom_range(0, 3) == 0);
    rnd_wr_full  = rand_bp && ($urandom_range(0, 3) == 0);
  end

  task automatic tick(); @(posedge ifclk); #1; endtask

  task automatic ref_cmds(input logic [2:0] instr, input logic [29:0] a, input int nw);
    logic [29:0] ca; int left, n; cmd_t c;
    exp_q.delete(); ca = {a[29:2], 2'b00}; left = nw;
    while (left > 0) begin
      n = (left > BW) ? BW : left;
      c.instr = instr; c.bl = 6'(n - 1); c.addr = ca;
      exp_q.push_back(c);
      ca = ca + 30'(4 * n); left -= n;
    end
  endtask

  task automatic check_cmds(input int c0, input bit is_rd, input int pops0);
    int sum;
    sum = 0;
    chk("cmd_count", cmd_log.size() - c0, exp_q.size());
    for (int i = 0; i < exp_q.size() && c0 + i < cmd_log.size(); i++) begin
      chk("cmd_instr", cmd_log[c0+i].instr, exp_q[i].instr);
      chk("cmd_bl", cmd_log[c0+i].bl, exp_q[i].bl);
      chk("cmd_addr", cmd_log[c0+i].addr, exp_q[i].addr);
`ifndef DDR_PORT_CTRL_PREFETCH_EN
      if (is_rd) chk("rd_cmd_after_drain", cmd_pops[c0+i] - pops0, sum);
`endif
      sum += int'(exp_q[i].bl) + 1;
    end
  endtask

  task automatic run_write(input logic [29:0] a, input int nw, input int stall_at);
    logic [31:0] wd[$]; int sent, cyc, c0, wr0;
    c0 = cmd_log.size(); wr0 = wr_log.size();
    ref_cmds(3'b000, a, nw);
    di_term_addr = TERM; di_reg_addr = {2'b00, a}; di_write_mode = 1'b1; di_write = 1'b0;
    tick();
    sent = 0; cyc = 0;
    while (sent < nw && cyc < 4000) begin
      if (sent == stall_at && !force_wr_full) begin
        force_wr_full = 1; di_write = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge ifclk);
          chk("stall_wr_rdy", di_write_rdy, 0);
          chk("stall_no_wr", wr_log.size() - wr0, sent);
          tick();
        end
        force_wr_full = 0;
        stall_at = -1;
      end
      di_write = ($urandom_range(0, 3) != 0); di_reg_datai = $urandom;
      @(negedge ifclk);
      if (di_write && di_write_rdy) begin wd.push_back(di_reg_datai); sent++; end
      tick(); cyc++;
    end
    di_write = 1'b0; di_write_mode = 1'b0;
    cyc = 0;
    while (cmd_log.size() - c0 < exp_q.size() && cyc < 200) begin tick(); cyc++; end
    repeat (3) tick();
    chk("wr_words", wr_log.size() - wr0, nw);
    for (int i = 0; i < wd.size() && wr0 + i < wr_log.size(); i++) chk("wr_data", wr_log[wr0+i], wd[i]);
    check_cmds(c0, 1'b0, 0);
  endtask

  task automatic run_read(input logic [29:0] a, input int bytes, input int err_at);
    int nw, got, cyc, c0, pops0; logic [29:0] base;
    nw = bytes / 4; c0 = cmd_log.size(); pops0 = pops; base = {a[29:2], 2'b00};
    ref_cmds(3'b001, a, nw);
    di_term_addr = TERM; di_reg_addr = {2'b00, a}; di_len = bytes; di_read_mode = 1'b1; di_read = 1'b0;
    tick();
    got = 0; cyc = 0;
    while (got < nw && cyc < 4000) begin
      di_read = ($urandom_range(0, 3) != 0);
      inject_rd_err = (got == err_at);
      if (got == err_at) err_at = -1;
      @(negedge ifclk);
      if (di_read && di_read_rdy) begin
        chk("rd_data", di_reg_datao, rdat(base + 30'(4 * got)));
        got++;
      end
      tick(); cyc++;
      inject_rd_err = 0;
    end
    di_read = 1'b0;
    chk("rd_words", got, nw);
    di_read_mode = 1'b0;
    repeat (3) tick();
    check_cmds(c0, 1'b1, pops0);
  endtask

  typedef struct {
    bit wr; logic [29:0] addr; int bytes;
    int exp_ncmd; logic [5:0] exp_last_bl; logic [29:0] exp_last_addr; logic [15:0] exp_status;
  } vec_t;
  vec_t vt[6];

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, got, nw, bytes;
    logic [29:0] a;
    vt[0] = '{1'b1, 30'h100,      128, 1, 6'd31, 30'h100,  16'h0000};
    vt[1] = '{1'b1, 30'h0,        160, 2, 6'd7,  30'h80,   16'h0000};
    vt[2] = '{1'b0, 30'h3FFFFFF0, 200, 2, 6'd17, 30'h70,   16'h0000};
    vt[3] = '{1'b0, 30'h40,       6,   1, 6'd0,  30'h40,   16'h0010};
    vt[4] = '{1'b1, 30'h3FFFFFFC, 12,  1, 6'd2,  30'h3FFFFFFC, 16'h0000};
    vt[5] = '{1'b0, 30'h200,      256, 2, 6'd31, 30'h280,  16'h0000};

    repeat (2) tick();
    di_read = 1'b1;
    #1;
    chk("rst_cmd_en", p_cmd_en, 0);
    chk("rst_cmd_instr", p_cmd_instr, 0);
    chk("rst_cmd_bl", p_cmd_bl, 0);
    chk("rst_cmd_addr", p_cmd_byte_addr, 0);
    chk("rst_status", di_transfer_status, 0);
    chk("rst_write_rdy", di_write_rdy, 1);
    chk("rst_read_rdy", di_read_rdy, 1);
    chk("rst_datao", di_reg_datao, 0);
    chk("rst_rd_en", p_rd_en, 0);
    chk("rst_wr_en", p_wr_en, 0);
    chk("wr_mask", p_wr_mask, 0);
    di_read = 1'b0;
    resetb = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) begin
      c0 = cmd_log.size();
      if (vt[i].wr) run_write(vt[i].addr, vt[i].bytes / 4, (i == 0) ? 10 : -1);
      else run_read(vt[i].addr, vt[i].bytes, -1);
      chk("vec_ncmd", cmd_log.size() - c0, vt[i].exp_ncmd);
      chk("vec_last_bl", (cmd_log.size() > c0) ? cmd_log[$].bl : 6'h3F, vt[i].exp_last_bl);
      chk("vec_last_addr", (cmd_log.size() > c0) ? cmd_log[$].addr : 30'h0, vt[i].exp_last_addr);
      chk("vec_status", di_transfer_status, vt[i].exp_status);
    end

    // Sticky read error: set by a one-cycle pulse, held after the transfer, cleared by the next start.
    run_read(30'h300, 128, 5);
    chk("rd_err_status", di_transfer_status, 16'h0008);
    repeat (5) tick();
    chk("rd_err_held", di_transfer_status, 16'h0008);
    run_write(30'h400, 4, -1);
    chk("status_cleared", di_transfer_status, 16'h0000);

    // Reset in the middle of a read, then a clean read.
    di_term_addr = TERM; di_reg_addr = 32'h0000_1000; di_len = 512; di_read_mode = 1'b1;
    tick();
    got = 0;
    for (int k = 0; k < 400 && got < 10; k++) begin
      di_read = 1'b1;
      @(negedge ifclk);
      if (di_read_rdy) got++;
      tick();
    end
    chk("pre_rst_words", got, 10);
    @(negedge ifclk);
    resetb = 1'b0;
    #1;
    chk("mid_rst_cmd_en", p_cmd_en, 0);
    chk("mid_rst_cmd_instr", p_cmd_instr, 0);
    chk("mid_rst_cmd_bl", p_cmd_bl, 0);
    chk("mid_rst_cmd_addr", p_cmd_byte_addr, 0);
    chk("mid_rst_status", di_transfer_status, 0);
    chk("mid_rst_read_rdy", di_read_rdy, 1);
    chk("mid_rst_datao", di_reg_datao, 0);
    chk("mid_rst_rd_en", p_rd_en, 0);
    di_read = 1'b0; di_read_mode = 1'b0;
    repeat (2) tick();
    resetb = 1'b1;
    repeat (2) tick();
    run_read(30'h2000, 40, -1);
    chk("post_rst_status", di_transfer_status, 0);

    // Random transfers with random command and write FIFO backpressure.
    rand_bp = 1;
    for (int t = 0; t < 8; t++) begin
      a = 30'($urandom);
      nw = $urandom_range(1, 100);
      if ($urandom_range(0, 1) == 1) begin
        run_write(a, nw, -1);
        chk("rand_wr_status", di_transfer_status, 0);
      end else begin
        bytes = nw * 4 + $urandom_range(0, 3);
        run_read(a, bytes, -1);
        chk("rand_rd_status", di_transfer_status, ((bytes % 4) != 0) ? 16'h0010 : 16'h0000);
      end
    end
    rand_bp = 0;
    repeat (3) tick();
    chk("rd_underflows", underflows, 0);
    chk("rd_fifo_left", rd_fifo.size() + pend.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ddr_port_ctrl.md
# ddr_port_ctrl

Bridges the host data interface (`di_*` bus from the FX3 controller) to one Spartan-6 MCB user port (p1/p2/p3), so the PC can read and write DDR2 as a terminal. It sits in the project top beside the FPGA terminal, alongside the `di_term_addr` mux. It owns the MCB port exclusively: it segments host transfers into MCB bursts, issues commands, moves data through the port FIFOs, and reports port errors in `di_transfer_status`.

## Interface
- `TERM_ADDR`, 16'h0010: terminal address served; the block is active only when `di_term_addr == TERM_ADDR`.
- `BURST_WORDS`, 32: maximum words per MCB command, range 1..64; `cmd_bl = words-1`.
- `ifclk`  in  1: 48 MHz clock; also driven out on `p_clk`.
- `resetb`  in  1: asynchronous, active-low reset.
- `di_term_addr`  in  16: terminal select.
- `di_reg_addr`  in  32: starting byte address; `[29:0]` used, `[1:0]` forced to 0.
- `di_len`  in  32: transfer length in bytes.
- `di_write_mode`, `di_read_mode`  in  1: transfer active, level signals.
- `di_write`, `di_read`  in  1: word strobes.
- `di_reg_datai`  in  32: write word.
- `di_reg_datao`  out  32: read word.
- `di_write_rdy`, `di_read_rdy`  out  1: word may transfer this cycle.
- `di_transfer_status`  out  16: sticky error bits.
- `p_clk`  out  1: MCB port clock.
- `p_cmd_en`  out  1; `p_cmd_instr`  out  3; `p_cmd_bl`  out  6; `p_cmd_byte_addr`  out  30; `p_cmd_full`  in  1.
- `p_wr_en`  out  1; `p_wr_mask`  out  4, tied 0; `p_wr_data`  out  32; `p_wr_full`, `p_wr_underrun`, `p_wr_error`  in  1.
- `p_rd_en`  out  1; `p_rd_data`  in  32; `p_rd_empty`, `p_rd_overflow`, `p_rd_error`  in  1; `p_rd_count`  in  7.

## Operation
- States: IDLE, WR_FILL, WR_CMD, RD_CMD, RD_DRAIN.
- Selected means `di_term_addr == TERM_ADDR`.
- **IDLE -> WR_FILL** on a rising edge of selected `di_write_mode`. On entry:
  - latch `addr = di_reg_addr[29:2]<<2`
  - set `fill = 0`
  - clear status
- **WR_FILL:**
  - `di_write_rdy = !p_wr_full && fill < BURST_WORDS`.
  - `p_wr_en = di_write && di_write_rdy`; `p_wr_data = di_reg_datai`; `fill++` on each accepted word.
  - Go to WR_CMD when `fill == BURST_WORDS`, or when `di_write_mode` falls with `fill > 0`.
  - If `di_write_mode` falls with `fill == 0`, go to IDLE.
  - If both conditions hit in the same cycle, only one command is issued.
- **WR_CMD:**
  - Wait while `p_cmd_full`.
  - Then pulse `p_cmd_en` with `instr = 3'b000`, `bl = fill-1`, `byte_addr = addr`.
  - Then `addr += fill*4`, `fill = 0`, and return to WR_FILL if `di_write_mode` is still high, else IDLE.
- **IDLE -> RD_CMD** on a rising edge of selected `di_read_mode`. On entry:
  - latch `addr`
  - set `remaining = di_len>>2`
  - clear status
  - set `status[4]` if `di_len[1:0] != 0`
- **RD_CMD:**
  - Burst size `n = min(BURST_WORDS, remaining)`.
  - Issue when `!p_cmd_full` and `outstanding + n <= 64`. The command is `instr = 3'b001`, `bl = n-1`.
  - Then `addr += 4n`, `remaining -= n`, `outstanding += n`.
  - When `remaining == 0`, go to RD_DRAIN.
- **Read data path**, in RD_CMD and RD_DRAIN:
  - `di_read_rdy = !p_rd_empty`; `di_reg_datao = p_rd_data`.
  - `p_rd_en = di_read && di_read_rdy`.
  - Each pop decrements `outstanding`.
- **RD_DRAIN -> IDLE** when `outstanding == 0` or `di_read_mode` falls.
  - On an early abort, remaining FIFO words are discarded by popping until `outstanding == 0` before IDLE accepts a new transfer.
- **Not selected or IDLE:**
  - `di_*_rdy = 1` and `di_reg_datao = 0`.
  - `p_wr_en = p_rd_en = 0`.
- **Status bits**, sticky until the next transfer start: [0] `wr_underrun`, [1] `wr_error`, [2] `rd_overflow`, [3] `rd_error`, [4] unaligned length. Bits [15:5] are 0.
- Address arithmetic is modulo 2^30 and wraps silently.

## Timing
- Reset values:
  - state IDLE
  - `p_cmd_en`, `p_cmd_instr`, `p_cmd_bl`, `p_cmd_byte_addr` all 0
  - `fill`, `remaining`, `outstanding` all 0
  - `di_transfer_status` 0
- Reset mid-transfer returns the block to IDLE. MCB FIFOs are not flushed.
- Command outputs are registered, and `p_cmd_en` is a single-cycle pulse. The command issues 1 cycle after WR_CMD entry when `!p_cmd_full`.
- Data paths are combinational, zero added latency. A word is accepted on a cycle where strobe & rdy.
- Read data latency is governed by the MCB. The block adds none beyond command registration.

## Configuration
- `DDR_PORT_CTRL_PREFETCH_EN` defined: RD_CMD issues bursts back-to-back, limited only by `outstanding + n <= 64`.
- Undefined: at most one read burst is outstanding; the next command is issued only after `outstanding == 0`.

## Test plan
- **Single burst write:** `TERM_ADDR` selected, addr 0x100, 32 words of 0..31 -> one command with `instr=0`, `bl=31`, `byte_addr=0x100`; 32 `p_wr_en` pulses carrying data 0..31.
- **Partial final burst:** write 40 words at 0x0 -> commands (bl=31, addr 0x0), then (bl=7, addr 0x80).
- **Write backpressure:** `p_wr_full` held high for 5 cycles mid-burst -> `di_write_rdy` is 0 for those cycles, no word lost, and `fill` is unchanged.
- **Read of 200 bytes at 0x3FFFFFF0:**
  - with prefetch -> commands bl=31 at 0x3FFFFFF0, then bl=17 at 0x00000070 (wrapped); 50 words delivered in order.
  - without prefetch -> the second command issues only after the 32nd pop.
- **Errors:**
  - `di_len=6` -> `status[4]=1`.
  - `p_rd_error` pulse -> `status[3]` set and held until the next start.
- **Reset mid-read:** assert `resetb` low mid-read -> all outputs at reset values the next cycle, and a new read starts cleanly.
